i8080_bus_unit: RTL and testbench

Parametrised machine-cycle sequencer between the i8080 control unit and the external system bus. It accepts one bus request at a time from the core and runs the 8080 T1/T2/Tw/T3 sequence on the external pins, with optional DMA hold. It drives address, status, SYNC, DBIN, WR_n and WAIT, and returns read data to the core. It generalises the current data bus buffer with a configurable data/address width, configurable minimum wait states and back-to-back cycles.

---
 rtl/i8080_bus_unit_pkg.sv | 38 +++
 rtl/i8080_bus_status.sv | 29 ++
 rtl/i8080_bus_unit.sv | 184 ++++++++++++++++++
 tb/tb_i8080_bus_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i8080_bus_unit_pkg.sv
// Shared definitions for the i8080 bus unit: request type codes, status bit
// positions, sequencer states and the read/write classification helper.
package i8080_bus_unit_pkg;

  typedef enum logic [2:0] {
    BUS_FETCH  = 3'd0,
    BUS_MREAD  = 3'd1,
    BUS_MWRITE = 3'd2,
    BUS_SREAD  = 3'd3,
    BUS_SWRITE = 3'd4,
    BUS_IN     = 3'd5,
    BUS_OUT    = 3'd6,
    BUS_INTA   = 3'd7
  } bus_type_e;

  localparam int unsigned ST_MEMR  = 7;
  localparam int unsigned ST_INP   = 6;
  localparam int unsigned ST_M1    = 5;
  localparam int unsigned ST_OUT   = 4;
  localparam int unsigned ST_HLTA  = 3;
  localparam int unsigned ST_STACK = 2;
  localparam int unsigned ST_WO_N  = 1;
  localparam int unsigned ST_INTA  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_HOLD
  } bus_state_e;

  function automatic logic is_read(input bus_type_e t);
    return t inside {BUS_FETCH, BUS_MREAD, BUS_SREAD, BUS_IN, BUS_INTA};
  endfunction

endpackage

// File: rtl/i8080_bus_status.sv
// Combinational machine-cycle type to 8080 status byte encoder,
// zero-extended to XLEN.
module i8080_bus_status
  import i8080_bus_unit_pkg::*;
#(
  parameter int unsigned XLEN = 8
) (
  input  logic [2:0]      type_i,
  output logic [XLEN-1:0] status_o
);

  bus_type_e t;

  assign t = bus_type_e'(type_i);

  always_comb begin
    status_o           = '0;
    status_o[ST_MEMR]  = t inside {BUS_FETCH, BUS_MREAD, BUS_SREAD};
    status_o[ST_INP]   = (t == BUS_IN);
    status_o[ST_M1]    = t inside {BUS_FETCH, BUS_INTA};
    status_o[ST_OUT]   = (t == BUS_OUT);
    // No halt cycle is issued through this unit.
    status_o[ST_HLTA]  = 1'b0;
    status_o[ST_STACK] = t inside {BUS_SREAD, BUS_SWRITE};
    status_o[ST_WO_N]  = is_read(t);
    status_o[ST_INTA]  = (t == BUS_INTA);
  end

endmodule

// File: rtl/i8080_bus_unit.sv
// i8080 machine-cycle sequencer (T1/T2/Tw/T3) between core and system bus.
// Define I8080_BUS_HOLD_EN to add the DMA hold input and HOLD state.
module i8080_bus_unit
  import i8080_bus_unit_pkg::*;
#(
  parameter int unsigned XLEN     = 8,
  parameter int unsigned AWIDTH   = 2*XLEN,
  parameter int unsigned MIN_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [AWIDTH-1:0] addr,
  output logic              addr_oe,
  output logic [XLEN-1:0]   data_out,
  output logic              data_oe,
  input  logic [XLEN-1:0]   data_in,
  output logic              sync,
  output logic              dbin,
  output logic              write_n,
  input  logic              ready,
  output logic              wwait,
`ifdef I8080_BUS_HOLD_EN
  input  logic              hold,
`endif
  output logic              hlda
);

  localparam logic [3:0] MIN_WAIT_C = 4'(MIN_WAIT);

  bus_state_e        state_q, state_d;
  bus_type_e         type_q,  type_d;
  logic [AWIDTH-1:0] addr_q,  addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [3:0]        wcnt_q,  wcnt_d;
  logic              live_q;
  logic              hold_pend;
  logic              accept;
  logic              rd;
  logic [XLEN-1:0]   status;

`ifdef I8080_BUS_HOLD_EN
  assign hold_pend = hold;
`else
  assign hold_pend = 1'b0;
`endif

  assign rd        = is_read(type_q);
  assign addr      = addr_q;
  assign rsp_rdata = rdata_q;

  i8080_bus_status #(.XLEN(XLEN)) u_status (
    .type_i   (type_q),
    .status_o (status)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= BUS_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wcnt_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wcnt_q  <= wcnt_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wcnt_d    = wcnt_q;
    accept    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    addr_oe   = 1'b0;
    data_oe   = 1'b0;
    data_out  = '0;
    sync      = 1'b0;
    dbin      = 1'b0;
    write_n   = 1'b1;
    wwait     = 1'b0;
    hlda      = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = live_q && !hold_pend;
        if (req_valid && req_ready) begin
          accept = 1'b1;
        end else if (hold_pend) begin
          state_d = S_HOLD;
        end
      end

      S_T1: begin
        addr_oe  = 1'b1;
        data_oe  = 1'b1;
        data_out = status;
        sync     = 1'b1;
        wcnt_d   = MIN_WAIT_C;
        state_d  = S_T2;
      end

      S_T2, S_TW: begin
        addr_oe = 1'b1;
        wwait   = (state_q == S_TW);
        if (rd) begin
          dbin = 1'b1;
        end else begin
          data_oe  = 1'b1;
          data_out = wdata_q;
        end
        // Counter is decremented on entry to each Tw, so a zero count here
        // means MIN_WAIT wait states have already been inserted.
        if (ready && (wcnt_q == '0)) begin
          state_d = S_T3;
          if (rd) begin
            rdata_d = data_in;
          end
        end else begin
          state_d = S_TW;
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
      end

      S_T3: begin
        addr_oe   = 1'b1;
        rsp_valid = 1'b1;
        if (!rd) begin
          data_oe  = 1'b1;
          data_out = wdata_q;
          write_n  = 1'b0;
        end
        req_ready = !hold_pend;
        if (req_valid && req_ready) begin
          accept = 1'b1;
        end else if (hold_pend) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end

`ifdef I8080_BUS_HOLD_EN
      S_HOLD: begin
        hlda = 1'b1;
        if (!hold_pend) begin
          state_d = S_IDLE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_T1;
      type_d  = bus_type_e'(req_type);
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
  end

endmodule

// File: tb/tb_i8080_bus_unit.sv
// Directed bench for i8080_bus_unit: two instances (MIN_WAIT 0 and 3) checked
// every cycle against a transaction-level model plus literal spot checks.
module tb_i8080_bus_unit;

  localparam int MW0 = 0;
  localparam int MW1 = 3;

  localparam int T_FETCH  = 0;
  localparam int T_MREAD  = 1;
  localparam int T_MWRITE = 2;
  localparam int T_SREAD  = 3;
  localparam int T_SWRITE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  rv = 2'b00;
  logic [2:0]  req_type = 3'd0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic [7:0]  data_in = 8'h00;
  logic        ready = 1'b1;
  logic        hold_in = 1'b0;

  wire [1:0]  rr_w, rsp_valid_w, addr_oe_w, data_oe_w, sync_w, dbin_w, write_n_w, wwait_w, hlda_w;
  wire [15:0] addr_w [2];
  wire [7:0]  data_out_w [2];
  wire [7:0]  rsp_rdata_w [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Specification tables indexed by request type code.
  logic [7:0] STAT [8] = '{8'hA2, 8'h82, 8'h00, 8'h86, 8'h04, 8'h42, 8'h10, 8'h23};
  bit         RD   [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int         MW   [2] = '{MW0, MW1};

  always #5 clk = ~clk;

  i8080_bus_unit #(.XLEN(8), .AWIDTH(16), .MIN_WAIT(MW0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(rv[0]), .req_ready(rr_w[0]), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_w[0]), .rsp_rdata(rsp_rdata_w[0]),
    .addr(addr_w[0]), .addr_oe(addr_oe_w[0]),
    .data_out(data_out_w[0]), .data_oe(data_oe_w[0]), .data_in(data_in),
    .sync(sync_w[0]), .dbin(dbin_w[0]), .write_n(write_n_w[0]),
    .ready(ready), .wwait(wwait_w[0]),
`ifdef I8080_BUS_HOLD_EN
    .hold(hold_in),
`endif
    .hlda(hlda_w[0])
  );

  i8080_bus_unit #(.XLEN(8), .AWIDTH(16), .MIN_WAIT(MW1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_ready(rr_w[1]), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_w[1]), .rsp_rdata(rsp_rdata_w[1]),
    .addr(addr_w[1]), .addr_oe(addr_oe_w[1]),
    .data_out(data_out_w[1]), .data_oe(data_oe_w[1]), .data_in(data_in),
    .sync(sync_w[1]), .dbin(dbin_w[1]), .write_n(write_n_w[1]),
    .ready(ready), .wwait(wwait_w[1]),
`ifdef I8080_BUS_HOLD_EN
    .hold(hold_in),
`endif
    .hlda(hlda_w[1])
  );

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Model: ph 0 = idle, 1 = holding, 2 = inside a machine cycle.
  // Within a cycle m_t counts clocks since T1, m_nw counts Tw states so far,
  // m_end marks the final (T3) clock.
  int          m_ph   [2] = '{0, 0};
  int          m_t    [2] = '{0, 0};
  int          m_nw   [2] = '{0, 0};
  bit          m_end  [2] = '{1'b0, 1'b0};
  bit          m_live [2] = '{1'b0, 1'b0};
  int          m_ty   [2] = '{0, 0};
  logic [15:0] m_addr [2] = '{16'h0, 16'h0};
  logic [7:0]  m_wd   [2] = '{8'h0, 8'h0};
  logic [7:0]  m_rd   [2] = '{8'h0, 8'h0};

  function automatic bit exp_ready(input int i);
    return m_live[i] && (m_ph[i] == 0 || (m_ph[i] == 2 && m_end[i])) && !hold_in;
  endfunction

  task automatic m_start(input int i);
    m_ph[i]   = 2;
    m_t[i]    = 0;
    m_nw[i]   = 0;
    m_end[i]  = 1'b0;
    m_ty[i]   = int'(req_type);
    m_addr[i] = req_addr;
    m_wd[i]   = req_wdata;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = 0; m_t[i] = 0; m_nw[i] = 0; m_end[i] = 1'b0; m_live[i] = 1'b0;
        m_ty[i] = 0; m_addr[i] = '0; m_wd[i] = '0; m_rd[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit acc;
        acc = rv[i] && exp_ready(i);
        if (m_ph[i] == 0) begin
          if (acc) m_start(i);
          else if (hold_in) m_ph[i] = 1;
        end else if (m_ph[i] == 1) begin
          if (!hold_in) m_ph[i] = 0;
        end else if (m_end[i]) begin
          m_end[i] = 1'b0;
          if (acc) m_start(i);
          else m_ph[i] = hold_in ? 1 : 0;
        end else if (m_t[i] == 0) begin
          m_t[i] = 1;
        end else begin
          if (ready && m_nw[i] >= MW[i]) begin
            m_end[i] = 1'b1;
            if (RD[m_ty[i]]) m_rd[i] = data_in;
          end else begin
            m_nw[i]++;
          end
          m_t[i]++;
        end
        m_live[i] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit busy, fin, t1, mid, rdt, doe;
      busy = (m_ph[i] == 2);
      fin  = busy && m_end[i];
      t1   = busy && !m_end[i] && (m_t[i] == 0);
      mid  = busy && !m_end[i] && (m_t[i] >= 1);
      rdt  = RD[m_ty[i]];
      doe  = t1 || (busy && !rdt);
      chk("req_ready", i, 32'(rr_w[i]), 32'(exp_ready(i)));
      chk("rsp_valid", i, 32'(rsp_valid_w[i]), 32'(fin));
      chk("sync", i, 32'(sync_w[i]), 32'(t1));
      chk("addr_oe", i, 32'(addr_oe_w[i]), 32'(busy));
      chk("data_oe", i, 32'(data_oe_w[i]), 32'(doe));
      chk("dbin", i, 32'(dbin_w[i]), 32'(mid && rdt));
      chk("write_n", i, 32'(write_n_w[i]), 32'(!(fin && !rdt)));
      chk("wwait", i, 32'(wwait_w[i]), 32'(mid && m_t[i] >= 2));
      chk("hlda", i, 32'(hlda_w[i]), 32'(m_ph[i] == 1));
      if (busy) chk("addr", i, 32'(addr_w[i]), 32'(m_addr[i]));
      if (doe) chk("data_out", i, 32'(data_out_w[i]), 32'(t1 ? STAT[m_ty[i]] : m_wd[i]));
      if (fin && rdt) chk("rsp_rdata", i, 32'(rsp_rdata_w[i]), 32'(m_rd[i]));
    end
  end

  task automatic issue(input int inst, input int ty, input logic [15:0] a, input logic [7:0] wd);
    int n;
    @(posedge clk); #2;
    req_type  = 3'(ty);
    req_addr  = a;
    req_wdata = wd;
    rv[inst]  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rr_w[inst] && n < 50);
    chk("accept_timeout", inst, 32'(rr_w[inst]), 32'd1);
    @(posedge clk); #2;
    rv[inst] = 1'b0;
  endtask

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int n, ww, wn, ndb, s1, s2, nrv;
    bit done;

    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_addr", i, 32'(addr_w[i]), 32'h0);
      chk("rst_data_out", i, 32'(data_out_w[i]), 32'h0);
      chk("rst_rdata", i, 32'(rsp_rdata_w[i]), 32'h0);
      chk("rst_write_n", i, 32'(write_n_w[i]), 32'h1);
      chk("rst_req_ready", i, 32'(rr_w[i]), 32'h0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Single MREAD, zero waits.
    data_in = 8'h5A;
    ready   = 1'b1;
    issue(0, T_MREAD, 16'h1234, 8'h00);
    ndb = 0;
    @(negedge clk);
    chk("mread_t1_sync", 0, 32'(sync_w[0]), 32'h1);
    chk("mread_status", 0, 32'(data_out_w[0]), 32'h82);
    chk("mread_addr", 0, 32'(addr_w[0]), 32'h1234);
    ndb += int'(dbin_w[0]);
    @(negedge clk);
    ndb += int'(dbin_w[0]);
    @(negedge clk);
    ndb += int'(dbin_w[0]);
    chk("mread_rsp_cycle3", 0, 32'(rsp_valid_w[0]), 32'h1);
    chk("mread_rdata", 0, 32'(rsp_rdata_w[0]), 32'h5A);
    chk("mread_dbin_cycles", 0, 32'(ndb), 32'd1);

    // MWRITE with ready low for two samples.
    issue(0, T_MWRITE, 16'h2000, 8'h77);
    ready = 1'b0;
    ww = 0;
    wn = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      ww += int'(wwait_w[0]);
      wn += int'(!write_n_w[0]);
      if (c >= 2 && c <= 5) chk("mwrite_data", 0, 32'(data_out_w[0]), 32'h77);
      if (c == 5) chk("mwrite_strobe_t3", 0, 32'(write_n_w[0]), 32'h0);
      if (c == 4) ready = 1'b1;
    end
    chk("mwrite_tw_count", 0, 32'(ww), 32'd2);
    chk("mwrite_strobe_count", 0, 32'(wn), 32'd1);

    // FETCH on the MIN_WAIT=3 instance.
    issue(1, T_FETCH, 16'h0100, 8'h00);
    n = 0;
    ww = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (sync_w[1]) chk("fetch_status", 1, 32'(data_out_w[1]), 32'hA2);
      ww += int'(wwait_w[1]);
      if (rsp_valid_w[1]) done = 1'b1;
    end
    chk("fetch_clocks", 1, 32'(n), 32'd6);
    chk("fetch_tw_count", 1, 32'(ww), 32'd3);

    // Back-to-back SWRITE then SREAD with req_valid held.
    @(posedge clk); #2;
    data_in   = 8'hC3;
    req_type  = 3'(T_SWRITE);
    req_addr  = 16'h3000;
    req_wdata = 8'h5C;
    rv[0]     = 1'b1;
    s1 = -1;
    s2 = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (sync_w[0]) begin
        if (s1 < 0) begin
          s1 = c;
          chk("b2b_status1", 0, 32'(data_out_w[0]), 32'h04);
          req_type = 3'(T_SREAD);
          req_addr = 16'h3001;
        end else if (s2 < 0) begin
          s2 = c;
          chk("b2b_status2", 0, 32'(data_out_w[0]), 32'h86);
          rv[0] = 1'b0;
        end
      end
    end
    rv[0] = 1'b0;
    chk("b2b_sync_gap", 0, 32'(s2 - s1), 32'd3);

`ifdef I8080_BUS_HOLD_EN
    // Hold raised mid-cycle is taken only after T3.
    issue(0, T_MREAD, 16'h4000, 8'h00);
    @(posedge clk); #2;
    hold_in = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
      if (rsp_valid_w[0]) done = 1'b1;
    end
    chk("hold_cycle_done", 0, 32'(done), 32'h1);
    @(negedge clk);
    chk("hold_hlda", 0, 32'(hlda_w[0]), 32'h1);
    chk("hold_addr_oe", 0, 32'(addr_oe_w[0]), 32'h0);
    @(posedge clk); #2;
    req_type = 3'(T_MREAD);
    req_addr = 16'h4001;
    rv[0]    = 1'b1;
    @(negedge clk);
    chk("hold_wins_ready", 0, 32'(rr_w[0]), 32'h0);
    @(posedge clk); #2;
    hold_in = 1'b0;
    @(negedge clk);
    chk("hold_release_hlda", 0, 32'(hlda_w[0]), 32'h1);
    @(negedge clk);
    chk("hold_dropped_hlda", 0, 32'(hlda_w[0]), 32'h0);
    chk("hold_dropped_ready", 0, 32'(rr_w[0]), 32'h1);
    done = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
      if (sync_w[0]) done = 1'b1;
    end
    rv[0] = 1'b0;
    chk("hold_next_request", 0, 32'(done), 32'h1);
    repeat (4) @(negedge clk);
`endif

    // Reset asserted during Tw aborts the cycle.
    ready = 1'b0;
    issue(0, T_MREAD, 16'h5555, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("pre_rst_in_tw", 0, 32'(wwait_w[0]), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_wwait", 0, 32'(wwait_w[0]), 32'h0);
    chk("arst_dbin", 0, 32'(dbin_w[0]), 32'h0);
    chk("arst_addr_oe", 0, 32'(addr_oe_w[0]), 32'h0);
    chk("arst_addr", 0, 32'(addr_w[0]), 32'h0);
    chk("arst_rdata", 0, 32'(rsp_rdata_w[0]), 32'h0);
    chk("arst_write_n", 0, 32'(write_n_w[0]), 32'h1);
    chk("arst_req_ready", 0, 32'(rr_w[0]), 32'h0);
    chk("arst_rsp_valid", 0, 32'(rsp_valid_w[0]), 32'h0);
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    nrv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nrv += int'(rsp_valid_w[0]);
    end
    chk("arst_no_rsp", 0, 32'(nrv), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
